// File: rtl/temporizador_secuencial_n.sv
// Sequential dispense timer: drives N_CH motor/valve channels one at a time,
// from channel N_CH-1 down to channel 0, each for its latched cycle count.
// Zero-count channels are skipped without spending cycles.
//
// Ports:
//   i_clk       system clock, rising edge
//   i_reset     asynchronous active-low reset
//   i_trigger   start request, accepted only when idle
//   i_abort     synchronous cancel, wins over i_trigger
//   i_ciclos    per-channel counts, channel k at [k*CNT_W +: CNT_W]
//   o_motor_en  one-hot enable of the active channel
//   o_flags     per-channel completion flags (pulse or sticky, see FLAG_MODE)
//   o_ch_idx    index of the active channel, 0 when idle
//   o_busy      high while a channel is enabled
//   o_done      one-cycle pulse on normal sequence completion
module temporizador_secuencial_n #(
  parameter int unsigned N_CH      = 3,
  parameter int unsigned CNT_W     = 5,
  parameter int unsigned FLAG_MODE = 0,
  parameter int unsigned IDX_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_trigger,
  input  logic                  i_abort,
  input  logic [N_CH*CNT_W-1:0] i_ciclos,
  output logic [N_CH-1:0]       o_motor_en,
  output logic [N_CH-1:0]       o_flags,
  output logic [IDX_W-1:0]      o_ch_idx,
  output logic                  o_busy,
  output logic                  o_done
);

  typedef enum logic [1:0] {StIdle, StRun, StFin} state_e;

  state_e                r_state, w_state_d;
  logic [N_CH*CNT_W-1:0] r_shadow, w_shadow_d;
  logic [CNT_W-1:0]      r_cnt, w_cnt_d;
  logic [IDX_W-1:0]      r_idx, w_idx_d;
  logic [N_CH-1:0]       r_motor, w_motor_d;
  logic [N_CH-1:0]       r_flags, w_flags_d;
  logic                  r_busy, w_busy_d;
  logic                  r_done, w_done_d;

  logic                  w_first_found, w_next_found;
  logic [IDX_W-1:0]      w_first_idx, w_next_idx;
  logic [CNT_W-1:0]      w_cur_cnt;

  // Channel search. The first channel is picked from the live inputs because
  // the shadow copy is only loaded on the same edge. Later assignments win, so
  // the loop yields the highest qualifying index.
  always_comb begin
    w_first_found = 1'b0;
    w_first_idx   = '0;
    w_next_found  = 1'b0;
    w_next_idx    = '0;
    w_cur_cnt     = '0;
    for (int k = 0; k < int'(N_CH); k++) begin
      if (i_ciclos[k*CNT_W +: CNT_W] != '0) begin
        w_first_found = 1'b1;
        w_first_idx   = IDX_W'(k);
      end
      if ((k < int'(r_idx)) && (r_shadow[k*CNT_W +: CNT_W] != '0)) begin
        w_next_found = 1'b1;
        w_next_idx   = IDX_W'(k);
      end
      if (IDX_W'(k) == r_idx) begin
        w_cur_cnt = r_shadow[k*CNT_W +: CNT_W];
      end
    end
  end

  always_comb begin
    w_state_d  = r_state;
    w_shadow_d = r_shadow;
    w_cnt_d    = r_cnt;
    w_idx_d    = r_idx;
    w_motor_d  = r_motor;
    w_busy_d   = r_busy;
    w_done_d   = 1'b0;
    // Pulse flags drop every cycle; sticky flags hold until the next start.
    w_flags_d  = (FLAG_MODE != 0) ? r_flags : '0;

    if (i_abort) begin
      w_state_d = StIdle;
      w_cnt_d   = '0;
      w_idx_d   = '0;
      w_motor_d = '0;
      w_busy_d  = 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (i_trigger) begin
            w_shadow_d = i_ciclos;
            w_flags_d  = '0;
            if (w_first_found) begin
              w_state_d = StRun;
              w_cnt_d   = CNT_W'(1);
              w_idx_d   = w_first_idx;
              w_motor_d = N_CH'(1) << w_first_idx;
              w_busy_d  = 1'b1;
            end else begin
              w_state_d = StFin;
              w_done_d  = 1'b1;
            end
          end
        end
        StRun: begin
          if (r_cnt == w_cur_cnt) begin
            w_flags_d = w_flags_d | (N_CH'(1) << r_idx);
            if (w_next_found) begin
              w_cnt_d   = CNT_W'(1);
              w_idx_d   = w_next_idx;
              w_motor_d = N_CH'(1) << w_next_idx;
            end else begin
              w_state_d = StFin;
              w_done_d  = 1'b1;
              w_cnt_d   = '0;
              w_idx_d   = '0;
              w_motor_d = '0;
              w_busy_d  = 1'b0;
            end
          end else begin
            w_cnt_d = r_cnt + CNT_W'(1);
          end
        end
        StFin: begin
          w_state_d = StIdle;
        end
        default: begin
          w_state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state  <= StIdle;
      r_shadow <= '0;
      r_cnt    <= '0;
      r_idx    <= '0;
      r_motor  <= '0;
      r_flags  <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_d;
      r_shadow <= w_shadow_d;
      r_cnt    <= w_cnt_d;
      r_idx    <= w_idx_d;
      r_motor  <= w_motor_d;
      r_flags  <= w_flags_d;
      r_busy   <= w_busy_d;
      r_done   <= w_done_d;
    end
  end

  assign o_motor_en = r_motor;
  assign o_flags    = r_flags;
  assign o_ch_idx   = r_idx;
  assign o_busy     = r_busy;
  assign o_done     = r_done;

endmodule

// File: tb/tb_temporizador_secuencial_n.sv
module tb_temporizador_secuencial_n;
  localparam int W = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        trigger = 1'b0;
  logic        abort = 1'b0;
  logic [14:0] ciclos = '0;
  logic [2:0]  motor0, flags0, motor1, flags1;
  logic [1:0]  idx0, idx1;
  logic        busy0, busy1, done0, done1;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  temporizador_secuencial_n #(.N_CH(3), .CNT_W(W), .FLAG_MODE(0)) u_dut0 (
    .i_clk(clk), .i_reset(rst_n), .i_trigger(trigger), .i_abort(abort), .i_ciclos(ciclos),
    .o_motor_en(motor0), .o_flags(flags0), .o_ch_idx(idx0), .o_busy(busy0), .o_done(done0)
  );
  temporizador_secuencial_n #(.N_CH(3), .CNT_W(W), .FLAG_MODE(1)) u_dut1 (
    .i_clk(clk), .i_reset(rst_n), .i_trigger(trigger), .i_abort(abort), .i_ciclos(ciclos),
    .o_motor_en(motor1), .o_flags(flags1), .o_ch_idx(idx1), .o_busy(busy1), .o_done(done1)
  );

  // Reference model: an accepted start expands into a timeline of per-cycle
  // output records; each edge pops one record.
  typedef struct packed {
    logic [2:0] motor;
    logic [1:0] idx;
    logic       busy;
    logic       done;
    logic [2:0] flag;
  } ent_t;

  ent_t       plan[$];
  ent_t       cur;
  logic [2:0] sticky;

  function automatic void build_plan(input logic [14:0] c);
    ent_t       e;
    logic [2:0] pend;
    pend = 3'b0;
    plan.delete();
    for (int k = 2; k >= 0; k--) begin
      int n;
      n = int'((c >> (k * W)) & 15'd31);
      for (int i = 0; i < n; i++) begin
        e = '0;
        e.motor = 3'(1 << k);
        e.idx = 2'(k);
        e.busy = 1'b1;
        e.flag = (i == 0) ? pend : 3'b0;
        plan.push_back(e);
      end
      if (n > 0) pend = 3'(1 << k);
    end
    e = '0;
    e.done = 1'b1;
    e.flag = pend;
    plan.push_back(e);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      plan.delete();
      cur = '0;
      sticky = 3'b0;
    end else if (abort) begin
      plan.delete();
      cur = '0;
    end else begin
      if (!cur.busy && !cur.done && plan.size() == 0 && trigger) begin
        build_plan(ciclos);
        sticky = 3'b0;
      end
      if (plan.size() > 0) cur = plan.pop_front();
      else cur = '0;
      sticky = sticky | cur.flag;
    end
  end

  // Continuous scoreboard against the model, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if ({motor0, idx0, busy0, done0, flags0} !== {cur.motor, cur.idx, cur.busy, cur.done, cur.flag}) begin
        errors++;
        $display("FAIL model_mode0 t=%0t: got m=%b i=%0d b=%b d=%b f=%b, want m=%b i=%0d b=%b d=%b f=%b",
                 $time, motor0, idx0, busy0, done0, flags0,
                 cur.motor, cur.idx, cur.busy, cur.done, cur.flag);
      end
      checks++;
      if ({motor1, idx1, busy1, done1, flags1} !== {cur.motor, cur.idx, cur.busy, cur.done, sticky}) begin
        errors++;
        $display("FAIL model_mode1 t=%0t: got m=%b i=%0d b=%b d=%b f=%b, want m=%b i=%0d b=%b d=%b f=%b",
                 $time, motor1, idx1, busy1, done1, flags1,
                 cur.motor, cur.idx, cur.busy, cur.done, sticky);
      end
    end
  end

  // Presents counts and a trigger sampled at the next edge (cycle 0).
  task automatic go(input logic [14:0] c);
    ciclos = c;
    trigger = 1'b1;
    @(posedge clk);
    #1 trigger = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    checks++;
    if ({motor0, flags0, idx0, busy0, done0, motor1, flags1, idx1, busy1, done1} !== 20'b0) begin
      errors++;
      $display("FAIL reset_values: got %b want 0",
               {motor0, flags0, idx0, busy0, done0, motor1, flags1, idx1, busy1, done1});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [2:0] exp_m;
    int busy_n = 0;
    int done_c = -1;
    go({5'd3, 5'd2, 5'd4});
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      exp_m = (c <= 3) ? 3'b100 : (c <= 5) ? 3'b010 : (c <= 9) ? 3'b001 : 3'b000;
      checks++;
      if (motor0 !== exp_m) begin
        errors++;
        $display("FAIL basic_motor c=%0d: got %b want %b", c, motor0, exp_m);
      end
      if (busy0) busy_n++;
      if (done0 && done_c < 0) done_c = c;
      if (c == 4 || c == 6 || c == 10) begin
        checks++;
        if (flags0 !== ((c == 4) ? 3'b100 : (c == 6) ? 3'b010 : 3'b001)) begin
          errors++;
          $display("FAIL basic_flag c=%0d: got %b", c, flags0);
        end
      end
    end
    checks++;
    if (done_c != 10 || busy_n != 9) begin
      errors++;
      $display("FAIL basic_timing: got done@%0d busy=%0d want done@10 busy=9", done_c, busy_n);
    end
  endtask

  task automatic test_skip();
    logic f1 = 1'b0;
    int done_c = -1;
    logic busy_seen = 1'b0;
    go({5'd2, 5'd0, 5'd1});
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (flags0[1] || flags1[1] || motor0[1]) f1 = 1'b1;
      if (done0 && done_c < 0) done_c = c;
      if (c == 3) begin
        checks++;
        if (motor0 !== 3'b001 || idx0 !== 2'd0) begin
          errors++;
          $display("FAIL skip_jump: got m=%b i=%0d want m=001 i=0", motor0, idx0);
        end
      end
    end
    checks++;
    if (done_c != 4 || f1) begin
      errors++;
      $display("FAIL skip_timing: got done@%0d ch1_seen=%b want done@4 ch1_seen=0", done_c, f1);
    end
    done_c = -1;
    go(15'd0);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (busy0 || motor0 != 3'b0) busy_seen = 1'b1;
      if (done0 && done_c < 0) done_c = c;
    end
    checks++;
    if (done_c != 1 || busy_seen) begin
      errors++;
      $display("FAIL allzero: got done@%0d busy_seen=%b want done@1 busy_seen=0", done_c, busy_seen);
    end
  endtask

  task automatic test_max();
    int n [3] = '{0, 0, 0};
    int done_c = -1;
    go({5'd31, 5'd31, 5'd31});
    for (int c = 1; c <= 98; c++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) if (motor0[k]) n[k]++;
      if (done0 && done_c < 0) done_c = c;
    end
    checks++;
    if (n[0] != 31 || n[1] != 31 || n[2] != 31 || done_c != 94) begin
      errors++;
      $display("FAIL max_count: got %0d/%0d/%0d done@%0d want 31/31/31 done@94",
               n[2], n[1], n[0], done_c);
    end
  endtask

  task automatic test_mid_change();
    int busy_n = 0;
    int done_c = -1;
    go({5'd3, 5'd2, 5'd4});
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 2) ciclos = 15'($urandom);
      if (c == 5) trigger = 1'b1;
      if (c == 6) trigger = 1'b0;
      if (busy0) busy_n++;
      if (done0 && done_c < 0) done_c = c;
    end
    checks++;
    if (done_c != 10 || busy_n != 9) begin
      errors++;
      $display("FAIL mid_change: got done@%0d busy=%0d want done@10 busy=9", done_c, busy_n);
    end
  endtask

  task automatic test_abort();
    logic bad = 1'b0;
    go({5'd3, 5'd2, 5'd4});
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 5) abort = 1'b1;
      if (c == 6) begin
        abort = 1'b0;
        checks++;
        if (motor0 !== 3'b0 || busy0 !== 1'b0 || idx0 !== 2'd0) begin
          errors++;
          $display("FAIL abort_stop: got m=%b b=%b i=%0d want 000/0/0", motor0, busy0, idx0);
        end
      end
      if (c >= 6 && c <= 8) begin
        if (done0 || done1 || flags0[1] || flags1[1]) bad = 1'b1;
        checks++;
        if (flags1 !== 3'b100) begin
          errors++;
          $display("FAIL abort_sticky c=%0d: got %b want 100", c, flags1);
        end
      end
      if (c == 8) trigger = 1'b1;
      if (c == 9) begin
        trigger = 1'b0;
        checks++;
        if (motor0 !== 3'b100 || busy0 !== 1'b1) begin
          errors++;
          $display("FAIL abort_restart: got m=%b b=%b want 100/1", motor0, busy0);
        end
      end
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL abort_no_done: got done/flag1 seen=1 want 0");
    end
    for (int c = 0; c < 12; c++) @(negedge clk);
    trigger = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
    abort = 1'b0;
    checks++;
    if (motor0 !== 3'b0 || busy0 !== 1'b0 || done0 !== 1'b0) begin
      errors++;
      $display("FAIL abort_wins: got m=%b b=%b d=%b want 000/0/0", motor0, busy0, done0);
    end
    @(negedge clk);
  endtask

  task automatic test_sticky();
    go({5'd3, 5'd2, 5'd4});
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 4 || c == 6 || c == 10 || c == 12) begin
        checks++;
        if (flags1 !== ((c == 4) ? 3'b100 : (c == 6) ? 3'b110 : 3'b111)) begin
          errors++;
          $display("FAIL sticky_flag c=%0d: got %b", c, flags1);
        end
      end
    end
    go({5'd1, 5'd1, 5'd1});
    @(negedge clk);
    checks++;
    if (flags1 !== 3'b000) begin
      errors++;
      $display("FAIL sticky_clear: got %b want 000", flags1);
    end
    for (int c = 0; c < 6; c++) @(negedge clk);
  endtask

  task automatic test_async_reset();
    go({5'd3, 5'd2, 5'd4});
    for (int c = 1; c <= 3; c++) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({motor0, flags0, idx0, busy0, done0, motor1, flags1, idx1, busy1, done1} !== 20'b0) begin
      errors++;
      $display("FAIL async_reset: got %b want 0",
               {motor0, flags0, idx0, busy0, done0, motor1, flags1, idx1, busy1, done1});
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) @(negedge clk);
    checks++;
    if (busy0 !== 1'b0 || motor0 !== 3'b0) begin
      errors++;
      $display("FAIL no_resume: got b=%b m=%b want 0/000", busy0, motor0);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      trigger = ($urandom_range(0, 3) == 0);
      abort = ($urandom_range(0, 29) == 0);
      ciclos = {5'($urandom_range(0, 6)), 5'($urandom_range(0, 6)), 5'($urandom_range(0, 6))};
    end
    @(negedge clk);
    trigger = 1'b0;
    abort = 1'b0;
    for (int c = 0; c < 25; c++) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_skip();
    test_max();
    test_mid_change();
    test_abort();
    test_sticky();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/temporizador_secuencial_n.md
Name: temporizador_secuencial_n

Overview:
- Parametrised sequential dispense timer that drives N_CH motor/valve channels one at a time, each for a programmable number of clock cycles.
- Successor of the fixed 3-channel RGB timer, adding:
  - generic channel count and counter width;
  - per-channel one-hot enables;
  - zero-count channel skip;
  - abort;
  - busy/done status;
  - selectable pulse or sticky completion flags.
- Sits between the recipe/control FSM (which supplies cycle counts and trigger) and the motor drivers.

Parameters:
- N_CH, 3, number of channels (>=1); channel N_CH-1 runs first, channel 0 last.
- CNT_W, 5, width of each per-channel cycle count; max on-time 2^CNT_W-1 cycles.
- FLAG_MODE, 0, 0 = flags are 1-cycle pulses; 1 = flags are sticky until next accepted trigger.
- IDX_W, $clog2(N_CH) (min 1), width of ch_idx.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- trigger  in  1  start request, sampled on rising edge; accepted only in IDLE.
- abort  in  1  synchronous cancel; priority over trigger.
- ciclos  in  N_CH*CNT_W  per-channel cycle counts; channel k at bits [k*CNT_W +: CNT_W].
- motor_en  out  N_CH  one-hot enable of the active channel; all-zero when idle.
- flags  out  N_CH  per-channel completion flags; bit k = channel k finished.
- ch_idx  out  IDX_W  index of the active channel; 0 when idle.
- busy  out  1  high while any channel is enabled.
- done  out  1  1-cycle pulse when the full sequence completes normally.

Behaviour:
- Reset (reset low, asynchronous): state IDLE; motor_en, flags, ch_idx, busy, done, counter and shadow counts all 0. Release takes effect synchronously on the next edge.
- All outputs are registered. No combinational path from inputs to outputs.
- States:
  - IDLE: waiting for trigger.
  - RUN: a channel is enabled and its counter is advancing.
  - FIN: single cycle asserting done, then return to IDLE.
- IDLE with trigger=1 and abort=0 at edge E:
  - ciclos is latched into shadow registers. Later changes to ciclos have no effect on the running sequence.
  - Sticky flags are cleared.
  - The first channel is selected: the highest index with a nonzero latched count.
- Channel with count c>0:
  - motor_en[k] is high for exactly c consecutive cycles, starting the cycle after E (or directly after the previous channel's last cycle).
  - busy=1 and ch_idx=k for those cycles.
  - No gap cycle between consecutive channels.
- Channel with count 0 is skipped:
  - no enable cycles;
  - its flag is never asserted;
  - the skip search is combinational over the shadow counts and consumes no cycles.
- Completion of channel k (cycle after its last enable cycle):
  - FLAG_MODE=0: flags[k]=1 for exactly that one cycle.
  - FLAG_MODE=1: flags[k] is set and held.
- Sequence end: in the cycle after the last enabled cycle of the final nonzero channel, done=1 for one cycle and busy=0. done coincides with that channel's flag.
- All counts zero at trigger: no enables, busy stays 0, done pulses in the cycle after E (via FIN).
- Counter width is CNT_W. It counts 1..c and compares for equality; no wrap is possible since c <= 2^CNT_W-1.
- trigger while RUN/FIN: ignored, not queued.
- abort=1 at any edge:
  - next state IDLE; motor_en=0, busy=0, ch_idx=0;
  - no done and no flag for the interrupted channel;
  - already-set sticky flags are kept;
  - pending pulse flags are cleared.
- abort and trigger together in IDLE: abort wins, nothing starts.
- reset mid-sequence: immediate return to reset values. No resume after release.

Test Plan:
- N_CH=3, CNT_W=5, mode 0, ch2=3, ch1=2, ch0=4, trigger at cycle 0 ->
  - motor_en=100 cycles 1-3, 010 cycles 4-5, 001 cycles 6-9;
  - flags=100@4, 010@6, 001@10;
  - done@10; busy cycles 1-9.
- ch2=2, ch1=0, ch0=1 -> motor_en=100 cycles 1-2, 001 cycle 3; flags[1] never set; done@4. All-zero counts -> done@1 with busy never high.
- ch2=31, ch1=31, ch0=31 -> each enable exactly 31 cycles; done@94; no counter wrap.
- Mid-run: change ciclos at cycle 2 and pulse trigger at cycle 5 -> timing identical to the first scenario; no restart.
- abort at cycle 5 of the first scenario -> motor_en=000 and busy=0 from cycle 6; no done; flags[1] never set. A new trigger at cycle 8 restarts from ch2.
- FLAG_MODE=1, first scenario -> flags 100@4, 110@6, 111@10 and held; cleared at the next accepted trigger. Async reset low at cycle 3 -> all outputs 0 immediately, before the next clk edge.
